hazard3_irq_event_gen: RTL

//  Peripheral-side interrupt source: the driver end of one external IRQ line into the core's IRQ controller.

---
 rtl/hazard3_irq_event_gen.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/hazard3_irq_event_gen.sv
`default_nettype none
// ============================================================================
// Module   : hazard3_irq_event_gen
// Purpose  : Peripheral-side interrupt source. Captures up to 32 event inputs
//            into sticky W1C status bits, masks them with per-event enables
//            and drives one registered level IRQ. APB3 slave, zero wait.
//            Optional coalescing (macro HAZARD3_IRQGEN_COALESCE_EN) delays
//            IRQ assertion until an event-count threshold or a timeout.
// Ports    : clk, rst_n          clock, asynchronous active-low reset
//            apbs_*              APB3 slave (5-bit byte address)
//            event_in[N_EVENTS]  synchronous event inputs
//            irq                 level IRQ to the interrupt controller
// Revision : 1.0  initial release
// ============================================================================
module hazard3_irq_event_gen #(
  parameter int N_EVENTS = 16,
  parameter int W_COUNT  = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                apbs_psel,
  input  logic                apbs_penable,
  input  logic                apbs_pwrite,
  input  logic [4:0]          apbs_paddr,
  input  logic [31:0]         apbs_pwdata,
  output logic [31:0]         apbs_prdata,
  output logic                apbs_pready,
  output logic                apbs_pslverr,
  input  logic [N_EVENTS-1:0] event_in,
  output logic                irq
);

  localparam logic [2:0] c_addr_status   = 3'd0;
  localparam logic [2:0] c_addr_enable   = 3'd1;
  localparam logic [2:0] c_addr_trigger  = 3'd2;
  localparam logic [2:0] c_addr_force    = 3'd3;
  localparam logic [2:0] c_addr_coalesce = 3'd4;
  localparam logic [2:0] c_addr_raw      = 3'd5;

  logic [N_EVENTS-1:0] r_status;
  logic [N_EVENTS-1:0] r_enable;
  logic [N_EVENTS-1:0] r_trigger;
  logic [N_EVENTS-1:0] r_event_d;
  logic [N_EVENTS-1:0] w_hit;
  logic [N_EVENTS-1:0] w_w1c;
  logic [N_EVENTS-1:0] w_force;
  logic [N_EVENTS-1:0] w_status_nxt;
  logic [2:0]          w_reg_sel;
  logic                w_wr;
  logic                w_pend;
  logic                w_irq_nxt;
  logic [31:0]         w_coalesce_rd;
  logic                w_unused;

  assign w_reg_sel    = apbs_paddr[4:2];
  assign w_wr         = apbs_psel & apbs_penable & apbs_pwrite;
  assign apbs_pready  = 1'b1;
  assign apbs_pslverr = apbs_psel & apbs_penable & (w_reg_sel > c_addr_raw);
  assign w_unused     = &{1'b0, apbs_paddr[1:0], apbs_pwdata};

  // Edge detection runs regardless of ENABLE so enabling never fakes an edge.
  assign w_hit   = (r_trigger & event_in & ~r_event_d) | (~r_trigger & event_in);
  assign w_w1c   = (w_wr && w_reg_sel == c_addr_status) ? apbs_pwdata[N_EVENTS-1:0] : '0;
  assign w_force = (w_wr && w_reg_sel == c_addr_force)  ? apbs_pwdata[N_EVENTS-1:0] : '0;
  // Set sources win over a same-cycle W1C clear.
  assign w_status_nxt = w_hit | w_force | (r_status & ~w_w1c);
  assign w_pend       = |(r_status & r_enable);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_status  <= '0;
      r_enable  <= '0;
      r_trigger <= '0;
      r_event_d <= '0;
      irq       <= 1'b0;
    end else begin
      r_status  <= w_status_nxt;
      r_event_d <= event_in;
      irq       <= w_irq_nxt;
      if (w_wr && w_reg_sel == c_addr_enable)  r_enable  <= apbs_pwdata[N_EVENTS-1:0];
      if (w_wr && w_reg_sel == c_addr_trigger) r_trigger <= apbs_pwdata[N_EVENTS-1:0];
    end
  end

  always_comb begin
    apbs_prdata = 32'h0;
    case (w_reg_sel)
      c_addr_status:   apbs_prdata = 32'(r_status);
      c_addr_enable:   apbs_prdata = 32'(r_enable);
      c_addr_trigger:  apbs_prdata = 32'(r_trigger);
      c_addr_coalesce: apbs_prdata = w_coalesce_rd;
      c_addr_raw:      apbs_prdata = 32'(r_event_d);
      default:         apbs_prdata = 32'h0;
    endcase
  end

`ifdef HAZARD3_IRQGEN_COALESCE_EN
  localparam logic [1:0] c_st_idle  = 2'd0;
  localparam logic [1:0] c_st_count = 2'd1;
  localparam logic [1:0] c_st_fire  = 2'd2;

  logic [1:0]         r_state;
  logic [1:0]         w_state_nxt;
  logic [W_COUNT-1:0] r_threshold;
  logic [W_COUNT-1:0] r_timeout;
  logic [W_COUNT-1:0] r_cnt;
  logic [W_COUNT-1:0] r_tmr;
  logic [W_COUNT-1:0] w_cnt_nxt;
  logic [W_COUNT-1:0] w_tmr_nxt;
  logic               w_new;
  logic               w_fire_cond;

  // A newly pending enabled event: hit on a bit not already latched.
  assign w_new         = |(w_hit & r_enable & ~r_status);
  assign w_fire_cond   = (r_cnt >= r_threshold) ||
                         ((r_timeout != '0) && (r_tmr >= r_timeout));
  assign w_coalesce_rd = (32'(r_timeout) << 16) | 32'(r_threshold);

  // State and counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= c_st_idle;
      r_cnt       <= '0;
      r_tmr       <= '0;
      r_threshold <= '0;
      r_timeout   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_tmr   <= w_tmr_nxt;
      if (w_wr && w_reg_sel == c_addr_coalesce) begin
        r_threshold <= apbs_pwdata[W_COUNT-1:0];
        r_timeout   <= apbs_pwdata[16 +: W_COUNT];
      end
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_st_idle:  if (w_pend) w_state_nxt = c_st_count;
      c_st_count: begin
        if (!w_pend)          w_state_nxt = c_st_idle;
        else if (w_fire_cond) w_state_nxt = c_st_fire;
      end
      c_st_fire:  if (!w_pend) w_state_nxt = c_st_idle;
      default:    w_state_nxt = c_st_idle;
    endcase
  end

  // Saturating counters: restart on IDLE->COUNT, advance while counting.
  always_comb begin
    w_cnt_nxt = r_cnt;
    w_tmr_nxt = r_tmr;
    if (r_state == c_st_idle) begin
      if (w_pend) begin
        w_cnt_nxt = W_COUNT'(1);
        w_tmr_nxt = '0;
      end
    end else if (r_state == c_st_count) begin
      if (w_new && (r_cnt != '1)) w_cnt_nxt = r_cnt + 1'b1;
      if (r_tmr != '1)            w_tmr_nxt = r_tmr + 1'b1;
    end
  end

  // Output logic: irq register follows the state being entered.
  always_comb begin
    w_irq_nxt = (w_state_nxt == c_st_fire);
  end
`else
  assign w_coalesce_rd = 32'h0;
  assign w_irq_nxt     = w_pend;
`endif

endmodule
`default_nettype wire
